// File: rtl/q_fixed_pkg.sv
// Shared Q-format fixed-point definitions: default word sizes, constants,
// a generic saturation helper and the accumulator state encoding.
package q_fixed_pkg;

  localparam int Q_WIDTH = 32;
  localparam int Q_FBITS = 27;
  localparam int SAT_W   = 128;

  localparam logic [Q_WIDTH-1:0] Q_ONE = 32'h0800_0000;
  localparam logic [Q_WIDTH-1:0] Q_MAX = 32'h7FFF_FFFF;
  localparam logic [Q_WIDTH-1:0] Q_MIN = 32'h8000_0000;

  typedef enum logic {ACC, OUT} state_t;

  // Clamp a wide signed value into the signed range of a w-bit word.
  // The result is still SAT_W wide; callers keep the low w bits.
  function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] x,
                                                  input int unsigned w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (w - 1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/mult_Q.sv
// Full-precision signed multiplier feeding the Q-format product path.
module mult_Q
  import q_fixed_pkg::*;
#(
  parameter int WIDTH = Q_WIDTH
) (
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_p
);

  assign o_p = $signed(i_a) * $signed(i_b);

endmodule

// File: rtl/mac_accum_q.sv
// Streaming saturating multiply-accumulate: one signed Q-format sum per
// vector, vectors ended by s_last or force-terminated at MAX_LEN beats.
module mac_accum_q
  import q_fixed_pkg::*;
#(
  parameter int WIDTH   = Q_WIDTH,
  parameter int FBITS   = Q_FBITS,
  parameter int MAX_LEN = 1024,
  localparam int LW     = $clog2(MAX_LEN) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_a,
  input  logic [WIDTH-1:0] s_b,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_y,
  output logic [LW-1:0]    m_len,
  output logic             m_ovf,
  output logic             m_trunc
);

  state_t r_state, w_state_nx;

  logic signed [WIDTH-1:0] r_acc;
  logic [LW-1:0]           r_count;
  logic                    r_ovf;
  logic [WIDTH-1:0]        r_y;
  logic [LW-1:0]           r_len;
  logic                    r_movf;
  logic                    r_trunc;

  logic                      w_fire;
  logic                      w_pop;
  logic [2*WIDTH-1:0]        w_p_raw;
  logic signed [2*WIDTH-1:0] w_p_full;
  logic signed [2*WIDTH-1:0] w_p_shift;
  logic signed [SAT_W-1:0]   w_p_ext;
  logic signed [SAT_W-1:0]   w_p_sat;
  logic signed [WIDTH-1:0]   w_p;
  logic                      w_p_ovf;
  logic signed [WIDTH-1:0]   w_acc_base;
  logic signed [SAT_W-1:0]   w_sum_ext;
  logic signed [SAT_W-1:0]   w_sum_sat;
  logic signed [WIDTH-1:0]   w_sum;
  logic                      w_sum_ovf;
  logic [LW-1:0]             w_count_nx;
  logic                      w_end;

  mult_Q #(.WIDTH(WIDTH)) u_mult (
    .i_a (s_a),
    .i_b (s_b),
    .o_p (w_p_raw)
  );

  // Product: arithmetic shift back to Q format, then clamp to one word.
  assign w_p_full  = w_p_raw;
  assign w_p_shift = w_p_full >>> FBITS;
  assign w_p_ext   = SAT_W'(w_p_shift);
  assign w_p_sat   = sat(w_p_ext, WIDTH);
  assign w_p       = w_p_sat[WIDTH-1:0];
  assign w_p_ovf   = (w_p_sat != w_p_ext);

  // Sum: widened add so overflow is visible, then clamp (no wraparound).
  assign w_acc_base = (r_count == '0) ? '0 : r_acc;
  assign w_sum_ext  = SAT_W'(w_acc_base) + SAT_W'(w_p);
  assign w_sum_sat  = sat(w_sum_ext, WIDTH);
  assign w_sum      = w_sum_sat[WIDTH-1:0];
  assign w_sum_ovf  = (w_sum_sat != w_sum_ext);

  assign w_count_nx = r_count + 1'b1;
  assign w_end      = s_last | (w_count_nx == LW'(MAX_LEN));

  assign m_y     = r_y;
  assign m_len   = r_len;
  assign m_ovf   = r_movf;
  assign m_trunc = r_trunc;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ACC;
    else        r_state <= w_state_nx;
  end

  // Next state and handshake outputs; s_ready held low while in reset.
  always_comb begin
    w_state_nx = r_state;
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    w_fire     = 1'b0;
    w_pop      = 1'b0;
    case (r_state)
      ACC: begin
        s_ready = rst_n;
        w_fire  = s_valid & rst_n;
        if (w_fire && w_end) w_state_nx = OUT;
      end
      OUT: begin
        m_valid = 1'b1;
        w_pop   = m_ready;
        if (m_ready) w_state_nx = ACC;
      end
      default: w_state_nx = ACC;
    endcase
  end

  // Accumulator, beat counter, sticky overflow and the held result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_y     <= '0;
      r_len   <= '0;
      r_movf  <= 1'b0;
      r_trunc <= 1'b0;
    end else if (w_fire) begin
      r_acc   <= w_sum;
      r_count <= w_count_nx;
      r_ovf   <= r_ovf | w_p_ovf | w_sum_ovf;
      if (w_end) begin
        r_y     <= w_sum;
        r_len   <= w_count_nx;
        r_movf  <= r_ovf | w_p_ovf | w_sum_ovf;
        r_trunc <= ~s_last;
      end
    end else if (w_pop) begin
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_accum_q.sv
// Directed self-checking bench for mac_accum_q (default and MAX_LEN=4 builds).
module tb_mac_accum_q;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0, s_valid4 = 1'b0;
  logic [31:0] s_a = '0, s_b = '0;
  logic        s_last = 1'b0;
  logic        m_ready = 1'b0;
  logic        s_ready, m_valid, m_ovf, m_trunc;
  logic [31:0] m_y;
  logic [10:0] m_len;
  logic        s_ready4, m_valid4, m_ovf4, m_trunc4;
  logic [31:0] m_y4;
  logic [2:0]  m_len4;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mac_accum_q dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_a(s_a), .s_b(s_b), .s_last(s_last), .m_valid(m_valid),
    .m_ready(m_ready), .m_y(m_y), .m_len(m_len), .m_ovf(m_ovf), .m_trunc(m_trunc)
  );

  mac_accum_q #(.MAX_LEN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid4), .s_ready(s_ready4),
    .s_a(s_a), .s_b(s_b), .s_last(s_last), .m_valid(m_valid4),
    .m_ready(m_ready), .m_y(m_y4), .m_len(m_len4), .m_ovf(m_ovf4), .m_trunc(m_trunc4)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] b, input logic last, input bit use4);
    s_a = a; s_b = b; s_last = last;
    if (use4) s_valid4 = 1'b1; else s_valid = 1'b1;
    tick();
    s_valid = 1'b0; s_valid4 = 1'b0; s_last = 1'b0;
  endtask

  task automatic pop();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_chk++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_s_ready got %b want 0", s_ready); end
    n_chk++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid got %b want 0", m_valid); end
    n_chk++; if (m_y !== 32'h0) begin n_fail++; $display("FAIL rst_m_y got %h want 0", m_y); end
    n_chk++; if (m_len !== 11'd0) begin n_fail++; $display("FAIL rst_m_len got %0d want 0", m_len); end
    n_chk++; if ({m_ovf, m_trunc} !== 2'b00) begin n_fail++; $display("FAIL rst_flags got %b want 00", {m_ovf, m_trunc}); end
    rst_n = 1'b1;
    tick();
    n_chk++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_s_ready got %b want 1", s_ready); end
  endtask

  task automatic test_dot();
    beat(32'h0A00_0000, 32'h0600_0000, 1'b0, 1'b0);
    n_chk++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL dot_early_valid got %b want 0", m_valid); end
    beat(32'h1000_0000, 32'hFC00_0000, 1'b1, 1'b0);
    n_chk++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL dot_valid got %b want 1", m_valid); end
    n_chk++; if (m_y !== 32'hFF80_0000) begin n_fail++; $display("FAIL dot_y got %h want ff800000", m_y); end
    n_chk++; if (m_len !== 11'd2) begin n_fail++; $display("FAIL dot_len got %0d want 2", m_len); end
    n_chk++; if ({m_ovf, m_trunc} !== 2'b00) begin n_fail++; $display("FAIL dot_flags got %b want 00", {m_ovf, m_trunc}); end
    pop();
    n_chk++; if ({m_valid, s_ready} !== 2'b01) begin n_fail++; $display("FAIL dot_pop got %b want 01", {m_valid, s_ready}); end
  endtask

  task automatic test_single();
    m_ready = 1'b1;  // high on the edge m_valid rises: must not pop yet
    beat(32'h0800_0000, 32'h0800_0000, 1'b1, 1'b0);
    n_chk++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", m_valid); end
    n_chk++; if (m_y !== 32'h0800_0000) begin n_fail++; $display("FAIL single_y got %h want 08000000", m_y); end
    n_chk++; if (m_len !== 11'd1) begin n_fail++; $display("FAIL single_len got %0d want 1", m_len); end
    tick();
    m_ready = 1'b0;
    n_chk++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL single_popped got %b want 0", m_valid); end
  endtask

  task automatic test_saturate();
    beat(32'h4000_0000, 32'h4000_0000, 1'b1, 1'b0);
    n_chk++; if (m_y !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL satp_y got %h want 7fffffff", m_y); end
    n_chk++; if (m_ovf !== 1'b1) begin n_fail++; $display("FAIL satp_ovf got %b want 1", m_ovf); end
    pop();
    beat(32'hC000_0000, 32'h4000_0000, 1'b1, 1'b0);
    n_chk++; if (m_y !== 32'h8000_0000) begin n_fail++; $display("FAIL satn_y got %h want 80000000", m_y); end
    n_chk++; if (m_ovf !== 1'b1) begin n_fail++; $display("FAIL satn_ovf got %b want 1", m_ovf); end
    pop();
    beat(32'h0800_0000, 32'h0400_0000, 1'b1, 1'b0);
    n_chk++; if (m_y !== 32'h0400_0000) begin n_fail++; $display("FAIL clr_y got %h want 04000000", m_y); end
    n_chk++; if (m_ovf !== 1'b0) begin n_fail++; $display("FAIL clr_ovf got %b want 0", m_ovf); end
    pop();
    // -1 LSB * +1 LSB: shift floors toward -inf, giving -1 LSB rather than 0
    beat(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
    n_chk++; if (m_y !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL floor_y got %h want ffffffff", m_y); end
    pop();
  endtask

  task automatic test_sum_sat();
    beat(32'h2000_0000, 32'h1800_0000, 1'b0, 1'b0);
    beat(32'h2000_0000, 32'h1800_0000, 1'b0, 1'b0);
    beat(32'h0800_0000, 32'hF800_0000, 1'b1, 1'b0);
    n_chk++; if (m_y !== 32'h77FF_FFFF) begin n_fail++; $display("FAIL sums_y got %h want 77ffffff", m_y); end
    n_chk++; if ({m_ovf, m_len} !== {1'b1, 11'd3}) begin n_fail++; $display("FAIL sums_ovf_len got %b/%0d want 1/3", m_ovf, m_len); end
    pop();
  endtask

  task automatic test_backpressure();
    beat(32'h0800_0000, 32'h0400_0000, 1'b1, 1'b0);
    s_a = 32'h2000_0000; s_b = 32'h2000_0000; s_last = 1'b1; s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if ({s_ready, m_valid, m_y} !== {1'b0, 1'b1, 32'h0400_0000}) begin
        n_fail++; $display("FAIL bp_hold%0d got %b/%b/%h want 0/1/04000000", i, s_ready, m_valid, m_y);
      end
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
    pop();
    beat(32'h0800_0000, 32'h0800_0000, 1'b1, 1'b0);
    n_chk++; if ({m_y, m_len} !== {32'h0800_0000, 11'd1}) begin n_fail++; $display("FAIL bp_next got %h/%0d want 08000000/1", m_y, m_len); end
    pop();
  endtask

  task automatic test_gap();
    beat(32'h0800_0000, 32'h0800_0000, 1'b0, 1'b0);
    tick(); tick(); tick();
    n_chk++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL gap_valid got %b want 0", m_valid); end
    beat(32'h0800_0000, 32'h0800_0000, 1'b1, 1'b0);
    n_chk++; if ({m_y, m_len} !== {32'h1000_0000, 11'd2}) begin n_fail++; $display("FAIL gap_result got %h/%0d want 10000000/2", m_y, m_len); end
    pop();
  endtask

  task automatic test_maxlen();
    for (int i = 0; i < 4; i++) beat(32'h0800_0000, 32'h0800_0000, 1'b0, 1'b1);
    n_chk++; if (m_valid4 !== 1'b1) begin n_fail++; $display("FAIL trunc_valid got %b want 1", m_valid4); end
    n_chk++; if ({m_y4, m_len4, m_trunc4} !== {32'h2000_0000, 3'd4, 1'b1}) begin
      n_fail++; $display("FAIL trunc_result got %h/%0d/%b want 20000000/4/1", m_y4, m_len4, m_trunc4);
    end
    pop();
    beat(32'h0800_0000, 32'h0800_0000, 1'b1, 1'b1);
    n_chk++; if ({m_y4, m_len4, m_trunc4} !== {32'h0800_0000, 3'd1, 1'b0}) begin
      n_fail++; $display("FAIL fifth_result got %h/%0d/%b want 08000000/1/0", m_y4, m_len4, m_trunc4);
    end
    pop();
    for (int i = 0; i < 4; i++) beat(32'h0800_0000, 32'h0800_0000, (i == 3), 1'b1);
    n_chk++; if ({m_len4, m_trunc4} !== {3'd4, 1'b0}) begin n_fail++; $display("FAIL exact_len got %0d/%b want 4/0", m_len4, m_trunc4); end
    pop();
  endtask

  task automatic test_reset_mid();
    bit seen;
    beat(32'h0800_0000, 32'h0800_0000, 1'b0, 1'b0);
    beat(32'h0800_0000, 32'h0800_0000, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (m_valid === 1'b1) seen = 1'b1;
      tick();
    end
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b want 0", seen); end
    beat(32'h1000_0000, 32'h1000_0000, 1'b1, 1'b0);
    n_chk++; if ({m_valid, m_y, m_len} !== {1'b1, 32'h2000_0000, 11'd1}) begin
      n_fail++; $display("FAIL rstmid_result got %b/%h/%0d want 1/20000000/1", m_valid, m_y, m_len);
    end
    pop();
  endtask

  initial begin
    test_reset();
    test_dot();
    test_single();
    test_saturate();
    test_sum_sat();
    test_backpressure();
    test_gap();
    test_maxlen();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
